// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the 4-bit-per-channel colour type and a visibility helper.
package vga_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

    function automatic logic is_visible(input logic [31:0] h, input logic [31:0] v,
                                        input int unsigned h_vis, input int unsigned v_vis);
        return (h < h_vis) && (v < v_vis);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Enabled modulo-TOTAL counter for one raster axis; wrap flags the enabled step from TOTAL-1 back to 0.
module vga_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        wrap    = en && (count_q == LAST);
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: 25 MHz pixel strobe from 50 MHz, x/y counters, sync decode and registered colour.
// Define VGA_TEST_PATTERN_EN to replace renderer colour with eight 80-pixel vertical colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        pixel_en,
    output logic        frame_start,
    input  logic [3:0]  pixel_red,
    input  logic [3:0]  pixel_green,
    input  logic [3:0]  pixel_blue,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int unsigned H_LEN = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_LEN = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW    = $clog2(H_LEN);
    localparam int unsigned VW    = $clog2(V_LEN);

    localparam logic [31:0] HS_START = H_VISIBLE + H_FRONT;
    localparam logic [31:0] HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam logic [31:0] VS_START = V_VISIBLE + V_FRONT;
    localparam logic [31:0] VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

    logic          pixel_en_q, pixel_en_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_pend_q, frame_pend_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    rgb_t          rgb_q, rgb_d;
    rgb_t          src_rgb;
    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          h_wrap;
    logic          v_wrap;
    logic [31:0]   x_ext;
    logic [31:0]   y_ext;
    logic          h_sync_on;
    logic          v_sync_on;

    vga_axis_counter #(.TOTAL(H_LEN), .W(HW)) u_h_counter (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (pixel_en_q),
        .count (h_count),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_LEN), .W(VW)) u_v_counter (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (h_wrap),
        .count (v_count),
        .wrap  (v_wrap)
    );

    assign x_ext     = 32'(h_count);
    assign y_ext     = 32'(v_count);
    assign h_sync_on = (x_ext >= HS_START) && (x_ext < HS_END);
    assign v_sync_on = (y_ext >= VS_START) && (y_ext < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    always_comb begin
        bar_idx = 3'(x_ext[9:0] / 10'd80);
        src_rgb = '{red: {4{bar_idx[2]}}, green: {4{bar_idx[1]}}, blue: {4{bar_idx[0]}}};
    end
`else
    assign src_rgb = '{red: pixel_red, green: pixel_green, blue: pixel_blue};
`endif

    // Frame pending is set by the vertical wrap (and by reset) and fires frame_start
    // so that it lines up with the next pixel_en cycle showing (0,0).
    always_comb begin
        pixel_en_d    = !pixel_en_q;
        frame_start_d = frame_pend_q && !pixel_en_q;
        frame_pend_d  = v_wrap || (frame_pend_q && !frame_start_d);
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        if (pixel_en_q) begin
            rgb_d = is_visible(x_ext, y_ext, V_VISIBLE == 0 ? 0 : H_VISIBLE, V_VISIBLE) ? src_rgb : '0;
            hs_d  = !h_sync_on;
            vs_d  = !v_sync_on;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_en_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_pend_q  <= 1'b1;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
        end else begin
            pixel_en_q    <= pixel_en_d;
            frame_start_q <= frame_start_d;
            frame_pend_q  <= frame_pend_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign x           = x_ext;
    assign y           = y_ext;
    assign pixel_en    = pixel_en_q;
    assign frame_start = frame_start_q;
    assign vga_red     = rgb_q.red;
    assign vga_green   = rgb_q.green;
    assign vga_blue    = rgb_q.blue;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;

endmodule
